// File: rtl/fir_out_pkg.sv
// fir_out_pkg: shared sample/frame types and drain FSM states for the FIR output serializer.
package fir_out_pkg;
    localparam int DATA_W = 10;
    localparam int LANES  = 4;
    typedef logic signed [DATA_W-1:0] sample_t;
    typedef sample_t [LANES-1:0] frame_t;
    typedef logic [1:0] lane_t;
    typedef enum logic {IDLE, DRAIN} state_t;
endpackage

// File: rtl/frame_fifo.sv
// frame_fifo: DEPTH-entry FIFO of whole frames with combinational head read.
module frame_fifo
    import fir_out_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  frame_t                 din,
    output frame_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    frame_t mem [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        wr_d  = wr_q + {{AW{1'b0}}, push};
        rd_d  = rd_q + {{AW{1'b0}}, pop};
        level = wr_q - rd_q;
        full  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
        empty = wr_q == rd_q;
        dout  = mem[rd_q[AW-1:0]];
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_q[AW-1:0]] <= din;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
endmodule

// File: rtl/fir_out_serializer.sv
// fir_out_serializer: buffers four-lane FIR output frames and streams them one sample per cycle.
module fir_out_serializer
    import fir_out_pkg::*;
#(
    parameter int DATA_W = fir_out_pkg::DATA_W,
    parameter int LANES  = fir_out_pkg::LANES,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_enable,
    input  logic signed [DATA_W-1:0] filter_out0,
    input  logic signed [DATA_W-1:0] filter_out1,
    input  logic signed [DATA_W-1:0] filter_out2,
    input  logic signed [DATA_W-1:0] filter_out3,
    output logic signed [DATA_W-1:0] out_data,
    output logic [1:0]               out_lane,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam lane_t LAST = lane_t'(LANES - 1);
    frame_t frame, head;
    logic   full, empty, push_ok, pop_last;
    state_t state_q, state_d;
    lane_t  lane_cnt_q, lane_cnt_d;
    logic   overflow_q, overflow_d;
    // A full FIFO still accepts when the head frame retires on the same edge.
    always_comb begin
        frame      = {filter_out3, filter_out2, filter_out1, filter_out0};
        out_valid  = state_q == DRAIN;
        pop_last   = out_valid && out_ready && lane_cnt_q == LAST;
        push_ok    = clk_enable && (!full || pop_last);
        lane_cnt_d = (out_valid && out_ready) ? (pop_last ? '0 : lane_cnt_q + 1'b1) : lane_cnt_q;
        state_d    = (pop_last ? (level == LW'(1) && !push_ok) : (empty && !push_ok)) ? IDLE : DRAIN;
        overflow_d = overflow_q || (clk_enable && !push_ok);
        out_data   = out_valid ? head[lane_cnt_q] : '0;
        out_lane   = lane_cnt_q;
        out_last   = lane_cnt_q == LAST;
        overflow   = overflow_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lane_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            overflow_q <= overflow_d;
        end
    end
    frame_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .pop   (pop_last),
        .din   (frame),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );
endmodule

// File: tb/tb_fir_out_serializer.sv
// tb_fir_out_serializer: directed and random stimulus checked against a frame-queue reference model.
module tb_fir_out_serializer;
    logic       clk = 1'b0, reset = 1'b0, clk_enable = 1'b0, out_ready = 1'b0;
    logic [9:0] filter_out0 = '0, filter_out1 = '0, filter_out2 = '0, filter_out3 = '0;
    logic [9:0] out_data;
    logic [1:0] out_lane;
    logic       out_last, out_valid, overflow;
    logic [2:0] level;
    logic [39:0] mq[$];
    int         mlane = 0;
    bit         movf = 1'b0;
    int         passed = 0, fails = 0, total = 0;
    logic [9:0] sf_exp [4];

    always #5 clk = ~clk;

    fir_out_serializer dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .filter_out0(filter_out0), .filter_out1(filter_out1),
        .filter_out2(filter_out2), .filter_out3(filter_out3),
        .out_data(out_data), .out_lane(out_lane), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] lane_of(input logic [39:0] f, input int l);
        return f[l*10 +: 10];
    endfunction

    // Compare DUT against model state, advance the model by one edge, move to next negedge.
    task automatic tick();
        int n;
        bit pop, last;
        n = mq.size();
        chk("valid", out_valid, n > 0);
        chk("level", level, n);
        chk("overflow", overflow, movf);
        chk("lane", out_lane, mlane);
        chk("last", out_last, mlane == 3);
        if (n > 0) chk("data", out_data, lane_of(mq[0], mlane));
        pop  = n > 0 && out_ready;
        last = pop && mlane == 3;
        if (pop) begin
            if (last) begin
                void'(mq.pop_front());
                mlane = 0;
            end else mlane++;
        end
        if (clk_enable) begin
            if (n < 4 || last) mq.push_back({filter_out3, filter_out2, filter_out1, filter_out0});
            else movf = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit en, input bit rdy);
        clk_enable = en;
        out_ready  = rdy;
        {filter_out3, filter_out2, filter_out1, filter_out0} = {$urandom, $urandom};
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clk_enable = 1'b0;
        #1;
        mq.delete();
        mlane = 0;
        movf  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        sf_exp[0] = 10'd1; sf_exp[1] = 10'h3FE; sf_exp[2] = 10'd3; sf_exp[3] = 10'h200;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_lane", out_lane, 0);
        chk("rst_last", out_last, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single known frame
        clk_enable = 1'b1; out_ready = 1'b1;
        filter_out0 = 10'd1; filter_out1 = -10'sd2; filter_out2 = 10'd3; filter_out3 = -10'sd512;
        tick();
        clk_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("sf_data", out_data, sf_exp[i]);
            chk("sf_lane", out_lane, i);
            chk("sf_last", out_last, i == 3);
            tick();
        end
        chk("sf_idle", out_valid, 0);
        chk("sf_level", level, 0);

        // Backpressure
        drive(1, 0);
        for (int i = 0; i < 12; i++) drive(0, (i % 4 == 0) || (i % 4 == 3));

        // Burst with overflow
        for (int i = 0; i < 4; i++) drive(1, 0);
        chk("burst_level", level, 4);
        chk("burst_ovf", overflow, 0);
        drive(1, 0);
        chk("burst_ovf5", overflow, 1);
        chk("burst_level5", level, 4);
        for (int i = 0; i < 18; i++) drive(0, 1);
        chk("burst_empty", level, 0);

        // Full with simultaneous last-sample pop
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 0);
        for (int i = 0; i < 3; i++) drive(0, 1);
        chk("fp_lane3", out_lane, 3);
        drive(1, 1);
        chk("fp_level", level, 4);
        chk("fp_ovf", overflow, 0);
        for (int i = 0; i < 18; i++) drive(0, 1);

        // Sustained rate
        for (int f = 0; f < 100; f++)
            for (int c = 0; c < 4; c++) begin
                chk("sus_level", level <= 3'd1, 1);
                drive(c == 0, 1);
            end
        for (int i = 0; i < 4; i++) drive(0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) drive($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
        for (int i = 0; i < 40; i++) drive(0, 1);

        // Reset while lane 2 is presented
        drive(1, 1);
        drive(0, 1);
        drive(0, 1);
        chk("rmd_lane2", out_lane, 2);
        reset = 1'b0;
        #1;
        chk("rmd_valid", out_valid, 0);
        chk("rmd_level", level, 0);
        chk("rmd_ovf", overflow, 0);
        mq.delete();
        mlane = 0;
        movf  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drive(1, 1);
        chk("rmd_new_lane0", out_lane, 0);
        for (int i = 0; i < 6; i++) drive(0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fir_out_serializer.md
# fir_out_serializer

Output stage of the cascaded FIR datapath. Each enabled clock it captures the four parallel filter outputs as one frame and buffers frames in a small FIFO. It then emits them one sample per cycle on a single valid/ready stream, lane 0 first, so one downstream port can consume all four filter responses.

## Interface
Parameters:
- DATA_W, 10, width of each filter output sample (signed, same fixed-point format as the FIR outputs).
- LANES, 4, samples per frame, i.e. number of cascaded FIR outputs.
- DEPTH, 4, FIFO capacity in frames; must be a power of two, ≥ 2.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- clk_enable  in  1  frame strobe; the same enable that advances the FIR stages.
- filter_out0..filter_out3  in  DATA_W each  signed FIR outputs, lanes 0..3.
- out_data  out  DATA_W  serialized sample.
- out_lane  out  2  lane index of out_data.
- out_last  out  1  high when out_lane == LANES-1.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- level  out  $clog2(DEPTH)+1  frames currently stored, including the frame being drained.
- overflow  out  1  sticky; set when a frame is dropped.

## Operation
- Push: on a rising edge with clk_enable=1, all four lanes are written as one frame at the write pointer, if accepted.
- Accept rule: a frame is accepted if level < DEPTH, or if the head frame's last sample is popped in the same cycle. Otherwise the frame is dropped, overflow is set to 1, and all pointers are unchanged.
- Drain FSM, two states:
  - IDLE: level==0; out_valid=0. Moves to DRAIN on the cycle after an accepted push.
  - DRAIN: out_valid=1; out_data = head frame[lane_cnt]; out_lane = lane_cnt.
  - On a pop, lane_cnt increments.
  - On a pop with lane_cnt==LANES-1: lane_cnt wraps to 0, the read pointer advances, and level decrements. The FSM stays in DRAIN if level stays > 0 (counting a simultaneous push), else returns to IDLE.
- Stall: while out_valid && !out_ready, out_data, out_lane and out_last hold stable.
- Simultaneous push and last-sample pop: level is unchanged and both pointers advance.
- Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH. Full when the pointers differ only in the MSB.
- No arithmetic is done on samples; they are passed bit-exact, sign preserved.
- overflow clears only on reset.

## Timing
- Reset values: out_valid=0, out_data=0, out_lane=0, out_last=0, level=0, overflow=0, FSM=IDLE, pointers=0, lane_cnt=0. FIFO contents are don't-care.
- Reset asserted mid-frame discards all buffered data immediately. There is no partial-frame output after release.
- Latency: a frame pushed at edge N into an empty FIFO presents lane 0 with out_valid=1 after edge N (combinational read of registered storage). With out_ready held high, lane 3 is presented after edge N+3.
- level updates on the same edge as the push/pop that changes it.
- Sustained throughput without loss: one clk_enable per 4 cycles, with out_ready=1. Bursts of up to DEPTH back-to-back enables are absorbed.
- out_valid never drops while level > 0.

## Structure
- Package fir_out_pkg holds:
  - DATA_W and LANES constants.
  - typedef sample_t (signed [DATA_W-1:0]).
  - typedef frame_t (array of LANES sample_t).
  - typedef lane_t (logic [1:0]).
  - FSM state enum {IDLE, DRAIN}.
- Sub-module frame_fifo is a generic DEPTH×frame_t FIFO with push/pop/full/empty/level. fir_out_serializer adds the lane counter, FSM, accept rule and overflow flag on top of it.

## Test plan
- Single frame (lanes 0..3 = 10'sd1, -10'sd2, 10'sd3, -10'sd512), out_ready=1 -> four cycles output 1, -2, 3, -512 with out_lane 0..3, out_last only on the fourth; then out_valid=0 and level=0.
- Backpressure: out_ready toggles 1,0,0,1,... during a frame -> each sample is held stable while stalled, none is duplicated or skipped, and the order is preserved.
- Burst: 4 consecutive clk_enable with out_ready=0 -> level=4, overflow=0. A 5th enable -> overflow=1, level stays 4, and 16 samples later drain with the 5th frame absent.
- Full with simultaneous pop: level=4 and an enable on the same edge as the head frame's lane-3 pop -> frame accepted, level stays 4, overflow stays 0.
- Sustained: clk_enable every 4th cycle with out_ready=1 for 100 frames -> level never exceeds 1, and the output equals the input lane order exactly.
- Reset mid-drain: assert reset low while lane 2 is presented -> out_valid, level and overflow are 0 immediately. After release, a new frame drains starting at lane 0.
